// File: rtl/histogram_reduce7.sv
// histogram_reduce7
// -----------------
// Reduction stage behind the histogram map stage. When it is started, it reads
// every bin of the `hist` buffer in ascending order. It computes three results:
//   - the total count, which wraps modulo 2^DATA_W;
//   - the peak bin value;
//   - the index of the peak bin. On a tie, the lowest index wins.
// It then writes the three results to out_r[0..2]. The start/done/continue
// handshake is ap_ctrl_chain.
//
// Ports:
//   ap_clk, ap_rst         clock, synchronous active-high reset
//   ap_start               request one invocation
//   ap_done                invocation complete (held until ap_continue)
//   ap_continue            downstream acknowledge of ap_done
//   ap_idle, ap_ready      status: idle in S1 without a start / ready for next start
//   hist_address0/ce0/q0   read-only bin memory port, one-cycle read latency
//   out_r_address0/ce0/we0/d0  result memory write port (3 words)
module histogram_reduce7 #(
  parameter int NBINS  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] hist_address0,
  output logic              hist_ce0,
  input  logic [DATA_W-1:0] hist_q0,
  output logic [1:0]        out_r_address0,
  output logic              out_r_ce0,
  output logic              out_r_we0,
  output logic [DATA_W-1:0] out_r_d0
);

  // One-hot FSM encoding
  localparam logic [5:0] S1 = 6'b000001;  // idle / wait for start
  localparam logic [5:0] S2 = 6'b000010;  // issue bin read
  localparam logic [5:0] S3 = 6'b000100;  // accumulate returned bin
  localparam logic [5:0] S4 = 6'b001000;  // write sum
  localparam logic [5:0] S5 = 6'b010000;  // write peak value
  localparam logic [5:0] S6 = 6'b100000;  // write peak index, signal done

  localparam logic [ADDR_W:0] I_END = (ADDR_W + 1)'(NBINS);

  logic [5:0]        state_q, state_d;
  logic [ADDR_W:0]   i_q, i_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] maxv_q, maxv_d;
  logic [ADDR_W-1:0] maxi_q, maxi_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   i_prev;

  // i has already been advanced past the bin whose data arrives in S3.
  assign i_prev = i_q - 1'b1;

  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    sum_d          = sum_q;
    maxv_d         = maxv_q;
    maxi_d         = maxi_q;
    hist_ce0       = 1'b0;
    hist_address0  = i_q[ADDR_W-1:0];
    out_r_ce0      = 1'b0;
    out_r_we0      = 1'b0;
    out_r_address0 = 2'd0;
    out_r_d0       = sum_q;

    case (state_q)
      S1: begin
        if (ap_start && !done_q) begin
          i_d     = '0;
          sum_d   = '0;
          maxv_d  = '0;
          maxi_d  = '0;
          state_d = S2;
        end
      end
      S2: begin
        if (i_q == I_END) begin
          state_d = S4;
        end else begin
          hist_ce0 = 1'b1;
          i_d      = i_q + 1'b1;
          state_d  = S3;
        end
      end
      S3: begin
        sum_d = sum_q + hist_q0;
        // A strict compare keeps the first (lowest-index) bin on ties.
        if (hist_q0 > maxv_q) begin
          maxv_d = hist_q0;
          maxi_d = i_prev[ADDR_W-1:0];
        end
        state_d = S2;
      end
      S4: begin
        out_r_ce0      = 1'b1;
        out_r_we0      = 1'b1;
        out_r_address0 = 2'd0;
        out_r_d0       = sum_q;
        state_d        = S5;
      end
      S5: begin
        out_r_ce0      = 1'b1;
        out_r_we0      = 1'b1;
        out_r_address0 = 2'd1;
        out_r_d0       = maxv_q;
        state_d        = S6;
      end
      S6: begin
        out_r_ce0      = 1'b1;
        out_r_we0      = 1'b1;
        out_r_address0 = 2'd2;
        out_r_d0       = {{(DATA_W - ADDR_W){1'b0}}, maxi_q};
        state_d        = S1;
      end
      default: state_d = S1;
    endcase
  end

  // Done is held across idle cycles until downstream acknowledges it.
  // The acknowledge has priority over the set.
  always_comb begin
    done_d = done_q;
    if (state_q == S6) done_d = 1'b1;
    if (ap_continue)   done_d = 1'b0;
  end

  assign ap_done  = (state_q == S6) | done_q;
  assign ap_ready = (state_q == S6);
  assign ap_idle  = (state_q == S1) & ~ap_start;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S1;
      i_q     <= '0;
      sum_q   <= '0;
      maxv_q  <= '0;
      maxi_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      sum_q   <= sum_d;
      maxv_q  <= maxv_d;
      maxi_q  <= maxi_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/histogram_reduce7.md
Name: histogram_reduce7

Overview:
- Downstream consumer of the ping-pong `hist` buffer filled by the histogram map stage.
- Once the map stage has completed its buffer, this block reads all bins of `hist` through a read-only memory port.
- It computes the total count, the peak bin value and the peak bin index, and writes these three words to a small `out_r` result memory.
- Uses the same ap_ctrl_chain handshake as the other dataflow stages, so it drops into the dataflow pipeline unchanged.

Parameters:
- NBINS, 256, number of histogram bins read per invocation.
- ADDR_W, 8, `hist` address width (log2 NBINS).
- DATA_W, 32, bin and result word width.

Ports:
- ap_clk  input  1  clock; all state updates on rising edge.
- ap_rst  input  1  synchronous reset, active-high.
- ap_start  input  1  request to run one invocation.
- ap_done  output  1  invocation complete.
- ap_continue  input  1  downstream acknowledge of done.
- ap_idle  output  1  block idle.
- ap_ready  output  1  ready for the next start.
- hist_address0  output  ADDR_W  bin read address.
- hist_ce0  output  1  read enable.
- hist_q0  input  DATA_W  read data, valid the cycle after ce0 is asserted.
- out_r_address0  output  2  result word address.
- out_r_ce0  output  1  result memory enable.
- out_r_we0  output  1  result write enable.
- out_r_d0  output  DATA_W  result write data.

Behaviour:
- Reset:
  - FSM goes to S1, done_reg=0, accumulators cleared.
  - All ce/we outputs are 0 and ap_done/ap_ready are 0.
  - ap_idle = ~ap_start.
  - Address and data outputs are don't-care while their enable is low.
- Registers: i (9 bit), sum, maxv, maxi (8 bit), done_reg.
- FSM is one-hot with 6 states:
  - S1 idle: start is accepted when ap_start & ~done_reg. On accept, clear i, sum, maxv and maxi; next state S2. ap_idle = ap_start==0 in S1 only.
  - S2 issue: if i==NBINS, go to S4. Else drive hist_address0=i[7:0] and hist_ce0=1, set i<=i+1, go to S3.
  - S3 accumulate:
    - sum <= sum + hist_q0, modulo 2^32 (wraps, no saturation).
    - If hist_q0 > maxv (unsigned, strict), then maxv <= hist_q0 and maxi <= i-1.
    - Next state S2.
  - S4: write out_r[0]=sum (ce0=we0=1). Next state S5.
  - S5: write out_r[1]=maxv. Next state S6.
  - S6:
    - Write out_r[2]={24'b0,maxi}.
    - ap_done=1 and ap_ready=1 combinationally.
    - If ~ap_continue, set done_reg.
    - Next state S1.
- Done holding:
  - ap_done = done_reg whenever not in S6.
  - done_reg clears on any cycle with ap_continue=1; ap_continue has priority over the set.
  - While done_reg=1, a new start is refused: FSM stays in S1 and ap_idle follows ap_start.
- Latency:
  - Start accepted at edge 0; S2/S3 alternate for 512 cycles; final S2 at cycle 513; S4/S5/S6 at 514/515/516.
  - ap_done is high in cycle 516, so the block can start again 517 cycles after acceptance.
- Exactly NBINS reads per run, addresses 0..255 ascending, one read per 2 cycles. `hist` is never written.
- Ties in max: the lowest index wins. All-zero histogram gives maxv=0, maxi=0.
- Reset mid-run: return to S1 on the next edge, with no further `hist` reads or `out_r` writes. Partial results are discarded; `out_r` may retain words from a previous run.
- ap_start deasserted mid-run: ignored; the run completes.

Test Plan:
1. All-zero `hist`, ap_continue=1, start pulse -> 256 reads at addresses 0..255; out_r = {0,0,0}; ap_done=1 exactly in cycle 516 for one cycle; done_reg stays 0.
2. hist[i]=i -> out_r[0]=32640, out_r[1]=255, out_r[2]=255.
3. hist[10]=hist[200]=7, all others 3 -> sum=2 + 254*3... i.e. 14+762=776; max=7; idx=10 (lowest index wins the tie).
4. hist[0]=0xFFFFFFFF, hist[1]=2, rest 0 -> sum=0x00000001 (wrap); max=0xFFFFFFFF; idx=0.
5. ap_continue=0 at completion, ap_start held high:
   - ap_done stays high and no restart occurs for 20 cycles.
   - Pulse ap_continue -> done drops next cycle; restart is accepted the cycle after.
6. Assert ap_rst in the 100th S3 cycle:
   - Next cycle: S1, ap_done=0, hist_ce0=0, no out_r writes.
   - A fresh start then produces full correct results (rerun scenario 2).
